// File: rtl/sll_pipe.sv
// sll_pipe: registered, flow-controlled logical-left-shift stage.
// A 2-entry elastic buffer (output register + skid register) sustains one
// transfer per cycle with no combinational path from i_READY to o_READY.
//
// Ports:
//   i_CLK, i_RESET_N          clock, asynchronous active-low reset
//   i_VALID, o_READY          upstream handshake (o_READY is a flop)
//   i_INPUT, i_SHIFT_AMOUNT   operand word and shift distance
//   o_VALID, i_READY          downstream handshake
//   o_RESULT, o_LOST          shifted word and "a 1 was shifted out" flag
module sll_pipe #(
    parameter int unsigned p_DATA_WIDTH = 4
) (
    input  logic                                i_CLK,
    input  logic                                i_RESET_N,
    input  logic                                i_VALID,
    output logic                                o_READY,
    input  logic [p_DATA_WIDTH-1:0]             i_INPUT,
    input  logic [$clog2(p_DATA_WIDTH)-1:0]     i_SHIFT_AMOUNT,
    output logic                                o_VALID,
    input  logic                                i_READY,
    output logic [p_DATA_WIDTH-1:0]             o_RESULT,
    output logic                                o_LOST
);

    localparam int unsigned lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH);
    localparam int unsigned lp_WIDE_WIDTH    = 2 * p_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic                          valid_q, valid_d;
    logic                          ready_q, ready_d;
    logic [p_DATA_WIDTH-1:0]       result_q, result_d;
    logic                          lost_q, lost_d;
    logic [p_DATA_WIDTH-1:0]       skid_data_q, skid_data_d;
    logic [lp_SFT_AMT_WIDTH-1:0]   skid_sft_q, skid_sft_d;

    logic                          accept;
    logic                          deliver;
    logic                          load_out;
    logic [p_DATA_WIDTH-1:0]       src_data;
    logic [lp_SFT_AMT_WIDTH-1:0]   src_sft;
    logic [lp_WIDE_WIDTH-1:0]      wide;

    // Next-state, buffer steering and shift arithmetic.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        lost_d      = lost_q;
        skid_data_d = skid_data_q;
        skid_sft_d  = skid_sft_q;
        load_out    = 1'b0;

        accept  = i_VALID && ready_q;
        deliver = valid_q && i_READY;

        // Output register reloads from the skid only when draining it.
        src_data = (state_q == ST_SKID) ? skid_data_q : i_INPUT;
        src_sft  = (state_q == ST_SKID) ? skid_sft_q  : i_SHIFT_AMOUNT;

        // Shift into a double-width word: the low half is the result and
        // any set bit in the high half was shifted out.
        wide = lp_WIDE_WIDTH'(src_data) << src_sft;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_FULL;
                    load_out = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && deliver) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d     = ST_SKID;
                    skid_data_d = i_INPUT;
                    skid_sft_d  = i_SHIFT_AMOUNT;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (deliver) begin
                    state_d  = ST_FULL;
                    load_out = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (load_out) begin
            result_d = wide[p_DATA_WIDTH-1:0];
            lost_d   = |wide[lp_WIDE_WIDTH-1:p_DATA_WIDTH];
        end

        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_SKID);
    end

    // State and datapath registers.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            result_q    <= '0;
            lost_q      <= 1'b0;
            skid_data_q <= '0;
            skid_sft_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            result_q    <= result_d;
            lost_q      <= lost_d;
            skid_data_q <= skid_data_d;
            skid_sft_q  <= skid_sft_d;
        end
    end

    assign o_VALID  = valid_q;
    assign o_READY  = ready_q;
    assign o_RESULT = result_q;
    assign o_LOST   = lost_q;

endmodule

// File: tb/tb_sll_pipe.sv
// Testbench for sll_pipe: occupancy/queue reference model with a per-cycle
// compare process, plus directed literal checks and randomized traffic.
module tb_sll_pipe;

    localparam int unsigned W  = 4;
    localparam int unsigned SW = $clog2(W);

    logic          i_CLK;
    logic          i_RESET_N;
    logic          i_VALID;
    logic          o_READY;
    logic [W-1:0]  i_INPUT;
    logic [SW-1:0] i_SHIFT_AMOUNT;
    logic          o_VALID;
    logic          i_READY;
    logic [W-1:0]  o_RESULT;
    logic          o_LOST;

    sll_pipe #(.p_DATA_WIDTH(W)) dut (
        .i_CLK          (i_CLK),
        .i_RESET_N      (i_RESET_N),
        .i_VALID        (i_VALID),
        .o_READY        (o_READY),
        .i_INPUT        (i_INPUT),
        .i_SHIFT_AMOUNT (i_SHIFT_AMOUNT),
        .o_VALID        (o_VALID),
        .i_READY        (i_READY),
        .o_RESULT       (o_RESULT),
        .o_LOST         (o_LOST)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    // Expected entries held by the stage, oldest first: {lost, result}.
    logic [W:0] q[$];

    function automatic logic [W:0] ref_shift(input int d, input int s);
        int res;
        int lost;
        res  = (d << s) % (1 << W);
        lost = (s > 0 && (d >> (W - s)) != 0) ? 1 : 0;
        return {lost[0], res[W-1:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a 2-deep FIFO of computed results.
    always @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            q.delete();
        end else begin
            logic acc;
            logic dlv;
            acc = i_VALID && (q.size() < 2);
            dlv = (q.size() > 0) && i_READY;
            if (dlv) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_shift(int'(i_INPUT), int'(i_SHIFT_AMOUNT)));
                n_acc++;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge i_CLK) begin
        chk("cyc_valid", int'(o_VALID), (q.size() > 0) ? 1 : 0);
        chk("cyc_ready", int'(o_READY), (q.size() < 2) ? 1 : 0);
        if (q.size() > 0 && o_VALID) begin
            chk("cyc_result", int'(o_RESULT), int'(q[0][W-1:0]));
            chk("cyc_lost", int'(o_LOST), int'(q[0][W]));
        end
    end

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input int s);
        i_VALID        = v;
        i_INPUT        = W'(d);
        i_SHIFT_AMOUNT = SW'(s);
    endtask

    int bnd_d[3]  = '{4'b1011, 4'b0001, 4'b1111};
    int bnd_s[3]  = '{3, 3, 0};
    int bnd_r[3]  = '{4'b1000, 4'b1000, 4'b1111};
    int bnd_l[3]  = '{1, 0, 0};
    int strm_r[4] = '{1, 2, 4, 8};

    initial begin
        int cyc;
        logic r0;

        i_RESET_N = 1'b0;
        i_READY   = 1'b1;
        drive(1'b0, 0, 0);
        #12;
        chk("rst_valid", int'(o_VALID), 0);
        chk("rst_ready", int'(o_READY), 1);
        chk("rst_result", int'(o_RESULT), 0);
        chk("rst_lost", int'(o_LOST), 0);
        @(negedge i_CLK);
        i_RESET_N = 1'b1;

        // Single transfer.
        step();
        drive(1'b1, 4'b0011, 2);
        step();
        drive(1'b0, 0, 0);
        chk("single_valid", int'(o_VALID), 1);
        chk("single_result", int'(o_RESULT), 4'b1100);
        chk("single_lost", int'(o_LOST), 0);
        step();
        chk("single_empty", int'(o_VALID), 0);

        // Lost-bit boundaries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bnd_d[i], bnd_s[i]);
            step();
            drive(1'b0, 0, 0);
            chk("bnd_result", int'(o_RESULT), bnd_r[i]);
            chk("bnd_lost", int'(o_LOST), bnd_l[i]);
            step();
        end

        // Back-to-back streaming.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1, i % 4);
            step();
            chk("strm_ready", int'(o_READY), 1);
            chk("strm_result", int'(o_RESULT), strm_r[i % 4]);
        end
        drive(1'b0, 0, 0);
        step();

        // Stall into skid.
        i_READY = 1'b0;
        drive(1'b1, 1, 1);
        step();
        drive(1'b1, 1, 2);
        step();
        chk("stall_ready", int'(o_READY), 0);
        chk("stall_result", int'(o_RESULT), 2);
        drive(1'b1, 4'b1111, 3);
        step();
        chk("stall_hold", int'(o_RESULT), 2);
        drive(1'b0, 0, 0);
        i_READY = 1'b1;
        step();
        chk("drain_result", int'(o_RESULT), 4);
        chk("drain_ready", int'(o_READY), 1);
        step();
        chk("drain_empty", int'(o_VALID), 0);

        // Reset while in SKID.
        i_READY = 1'b0;
        drive(1'b1, 1, 1);
        step();
        drive(1'b1, 1, 2);
        step();
        drive(1'b0, 0, 0);
        chk("pre_rst_ready", int'(o_READY), 0);
        #2;
        i_RESET_N = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_VALID), 0);
        chk("mid_rst_ready", int'(o_READY), 1);
        chk("mid_rst_result", int'(o_RESULT), 0);
        chk("mid_rst_lost", int'(o_LOST), 0);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_RESET_N = 1'b1;
        i_READY   = 1'b1;
        step();
        step();
        chk("post_rst_empty", int'(o_VALID), 0);

        // Randomized traffic on both sides.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            drive(($urandom % 4) != 0, int'($urandom % 16), int'($urandom % 4));
            i_READY = ($urandom % 3) != 0;
            #1;
            r0 = o_READY;
            i_READY = ~i_READY;
            #1;
            chk("ready_indep", int'(o_READY), int'(r0));
            i_READY = ~i_READY;
            step();
            cyc++;
        end
        chk("rand_accepts", n_acc, 1000);
        drive(1'b0, 0, 0);
        i_READY = 1'b1;
        step();
        step();
        step();
        chk("rand_drained", q.size(), 0);
        chk("rand_final_valid", int'(o_VALID), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
